// File: rtl/stagger_fifo_pkg.sv
// stagger_fifo shared defaults.
// Sizing constants reused by fifo_control.
package stagger_fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PTR_W      = $clog2(DEF_FIFO_WIDTH);
  localparam int DEF_CNT_W      = $clog2(DEF_FIFO_WIDTH) + 1;

  typedef logic [DEF_DATA_WIDTH-1:0] elem_t;
  typedef logic [DEF_CNT_W-1:0]      cnt_t;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_SWAP = 2'b11
  } cnt_op_e;

  function automatic cnt_op_e cnt_op(input logic wr,
                                     input logic rd);
    return cnt_op_e'({wr, rd});
  endfunction

endpackage

// File: rtl/stagger_fifo_skew_delay.sv
// Per-lane skew line: DEPTH enable-gated delay stages.
// bypass selects the undelayed input; DEPTH=0 is a wire.
module skew_delay
  import stagger_fifo_pkg::*;
#(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset, en, bypass};
    assign q = d;
  end else begin : g_line
    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
      if (reset) begin
        sr <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int k = 1; k < DEPTH; k++) begin
          sr[k] <= sr[k-1];
        end
      end
    end

    assign q = bypass ? d : sr[DEPTH-1];
  end

endmodule

// File: rtl/stagger_fifo.sv
// Row-wide FIFO feeding the systolic array.
// Lanes drain aligned or skewed by lane index.
module stagger_fifo
  import stagger_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [FIFO_WIDTH*DATA_WIDTH-1:0] push_data,
  input  logic [FIFO_WIDTH-1:0]            fifo_en,
  input  logic                             stagger,
  output logic [FIFO_WIDTH*DATA_WIDTH-1:0] data_out,
  output logic [$clog2(FIFO_WIDTH):0]      count,
  output logic                             full,
  output logic                             empty,
  output logic                             overflow
);

  localparam int PW = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
  localparam int CW = $clog2(FIFO_WIDTH) + 1;
  localparam int RW = FIFO_WIDTH * DATA_WIDTH;

  typedef logic [RW-1:0] row_t;

  row_t                                 mem [FIFO_WIDTH];
  logic [PW-1:0]                        wr_ptr;
  logic [PW-1:0]                        rd_ptr;
  logic [CW-1:0]                        count_q;
  logic                                 overflow_q;
  logic                                 draining;
  logic                                 stagger_q;
  logic [FIFO_WIDTH-1:0][DATA_WIDTH-1:0] stage0;

  logic pop;
  logic pop_ok;
  logic push_ok;
  row_t head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_WIDTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(FIFO_WIDTH));
  assign empty   = (count_q == '0);
  assign pop     = |fifo_en;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Popping while empty feeds a zero bubble into the lanes.
  assign head = pop_ok ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      unique case (cnt_op(push_ok, pop_ok))
        CNT_INC:  count_q <= count_q + CW'(1);
        CNT_DEC:  count_q <= count_q - CW'(1);
        CNT_HOLD,
        CNT_SWAP: count_q <= count_q;
        default:  count_q <= count_q;
      endcase
    end
  end

  // Skew mode is fixed for a whole drain burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      draining  <= 1'b0;
      stagger_q <= 1'b0;
    end else begin
      draining <= pop;
      if (pop && !draining) begin
        stagger_q <= stagger;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage0 <= '0;
    end else begin
      for (int i = 0; i < FIFO_WIDTH; i++) begin
        if (fifo_en[i]) begin
          stage0[i] <= head[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_lane
    skew_delay #(
      .DEPTH      (i),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
      .clk    (clk),
      .reset  (reset),
      .en     (fifo_en[i]),
      .bypass (!stagger_q),
      .d      (stage0[i]),
      .q      (data_out[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stagger_fifo.sv
// Self-checking bench for stagger_fifo.
// Queue/history reference model plus pinned literal checks.
module tb_stagger_fifo;

  localparam int W  = 16;
  localparam int DW = 8;
  localparam int CW = 5;
  localparam int RW = W * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic [RW-1:0] push_data = '0;
  logic [W-1:0]  fifo_en = '0;
  logic          stagger = 1'b0;
  logic [RW-1:0] data_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;

  stagger_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .fifo_en   (fifo_en),
    .stagger   (stagger),
    .data_out  (data_out),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] mq [$];
  logic [DW-1:0] hist [W][W];
  bit            m_ovf;
  bit            m_drn;
  bit            m_stq;

  task automatic chk(input string nm, input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int k);
    logic [RW-1:0] r;
    for (int i = 0; i < W; i++) r[i*DW +: DW] = DW'(16 * k + i);
    return r;
  endfunction

  // Reference: state after the coming posedge.
  task automatic model_step();
    logic [RW-1:0] head;
    bit pop, fl, em, acc;
    if (reset) begin
      mq.delete();
      m_ovf = 0;
      m_drn = 0;
      m_stq = 0;
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++) hist[i][j] = '0;
      return;
    end
    pop  = |fifo_en;
    fl   = (mq.size() == W);
    em   = (mq.size() == 0);
    acc  = push && (!fl || (pop && !em));
    head = '0;
    if (pop && !em) head = mq.pop_front();
    if (acc) mq.push_back(push_data);
    else if (push) m_ovf = 1;
    for (int i = 0; i < W; i++) begin
      if (fifo_en[i]) begin
        for (int j = W - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = head[i*DW +: DW];
      end
    end
    if (pop && !m_drn) m_stq = stagger;
    m_drn = pop;
  endtask

  task automatic cyc(input bit p, input logic [RW-1:0] d,
                     input logic [W-1:0] e, input bit st, input bit r);
    push = p;
    push_data = d;
    fifo_en = e;
    stagger = st;
    reset = r;
    model_step();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [RW-1:0] exp_d;
    #1;
    for (int i = 0; i < W; i++)
      exp_d[i*DW +: DW] = m_stq ? hist[i][i] : hist[i][0];
    chk("data_out", data_out, exp_d);
    chk("count", RW'(count), RW'(mq.size()));
    chk("full", RW'(full), RW'(mq.size() == W));
    chk("empty", RW'(empty), RW'(mq.size() == 0));
    chk("overflow", RW'(overflow), RW'(m_ovf));
  end

  localparam logic [W-1:0] ALL = '1;

  initial begin
    logic [W-1:0] e;
    int sel;
    cyc(0, '0, '0, 0, 1);
    cyc(0, '0, '0, 0, 1);
    chk("pin_reset_count", RW'(count), RW'(0));
    chk("pin_reset_empty", RW'(empty), RW'(1));
    chk("pin_reset_data", data_out, '0);

    for (int k = 1; k <= 16; k++) cyc(1, mkrow(k), '0, 0, 0);
    chk("pin_fill_count", RW'(count), RW'(16));
    chk("pin_fill_full", RW'(full), RW'(1));
    cyc(1, mkrow(17), '0, 0, 0);
    chk("pin_ovf", RW'(overflow), RW'(1));
    chk("pin_ovf_count", RW'(count), RW'(16));

    for (int k = 1; k <= 16; k++) begin
      cyc(0, '0, ALL, 0, 0);
      if (k == 5) chk("pin_align_l3", RW'(data_out[3*DW +: DW]), RW'(83));
    end
    chk("pin_align_empty", RW'(empty), RW'(1));
    cyc(0, '0, '0, 0, 0);
    cyc(0, '0, '0, 0, 0);

    cyc(0, '0, '0, 0, 1);
    for (int k = 1; k <= 16; k++) cyc(1, mkrow(k), '0, 1, 0);
    for (int c = 1; c <= 31; c++) begin
      cyc(0, '0, ALL, 1, 0);
      if (c == 1) begin
        chk("pin_stag_l0", RW'(data_out[0 +: DW]), RW'(16));
        chk("pin_stag_l1", RW'(data_out[DW +: DW]), RW'(0));
      end
      if (c == 31) chk("pin_stag_l15", RW'(data_out[15*DW +: DW]), RW'(15));
    end
    cyc(0, '0, '0, 0, 0);

    for (int k = 1; k <= 16; k++) cyc(1, mkrow(k + 20), '0, 0, 0);
    cyc(1, mkrow(40), ALL, 0, 0);
    chk("pin_fullpp_count", RW'(count), RW'(16));
    chk("pin_fullpp_ovf", RW'(overflow), RW'(0));
    for (int k = 0; k < 8; k++) cyc(0, '0, ALL, k >= 3, 0);
    cyc(0, '0, '0, 1, 0);
    for (int k = 0; k < 12; k++) cyc(0, '0, ALL, 0, 0);
    cyc(0, '0, '0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, '0, ALL, 0, 0);
    cyc(0, '0, '0, 0, 0);
    cyc(1, mkrow(50), ALL, 0, 0);
    chk("pin_emptypp_data", data_out, '0);
    chk("pin_emptypp_count", RW'(count), RW'(1));

    for (int k = 0; k < 4; k++) cyc(1, mkrow(60 + k), '0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, '0, 16'h0001, 0, 0);
    cyc(0, '0, 16'h0001, 0, 1);
    chk("pin_rst_data", data_out, '0);
    chk("pin_rst_count", RW'(count), RW'(0));
    chk("pin_rst_empty", RW'(empty), RW'(1));

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: e = '0;
        1: e = ALL;
        2: e = W'($urandom);
        default: e = W'(1) << $urandom_range(0, W - 1);
      endcase
      cyc($urandom_range(0, 99) < 55,
          {$urandom, $urandom, $urandom, $urandom}, e,
          $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
